// File: rtl/tug_game_ctrl.sv
// tug_game_ctrl -- game core of the tug-of-war design.
//
// Turns debounced player button presses into a rope position shown as a
// one-hot LED bar, detects a win at either end of the bar, and emits
// one-cycle pulses for the sound block (leds_on on win entry, clear on restart).
//
// Optional feature macro: SCORE_EN (adds score_l / score_r win counters).
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous, active-high reset
//   btn_l     in   left player button (synchronised, debounced, level)
//   btn_r     in   right player button (synchronised, debounced, level)
//   clr_btn   in   restart button (synchronised, debounced, level)
//   leds      out  one-hot rope position, bit 0 = left end
//   leds_on   out  1-cycle pulse, first cycle spent in WIN
//   clear     out  1-cycle pulse after a restart press
//   winner    out  00 none, 01 left, 10 right
//   score_l   out  left win count, saturating at 15 (SCORE_EN only)
//   score_r   out  right win count, saturating at 15 (SCORE_EN only)
//   state_dbg out  FSM state for checkers: 0 = PLAY, 1 = WIN
//
// No valid/ready handshakes: all inputs are levels and every press is an
// edge detected against a 1-flop history, so a held level counts once.

module tug_game_ctrl #(
    parameter int NUM_LEDS = 7,
    parameter int PW       = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_l,
    input  logic                btn_r,
    input  logic                clr_btn,
    output logic [NUM_LEDS-1:0] leds,
    output logic                leds_on,
    output logic                clear,
    output logic [1:0]          winner,
`ifdef SCORE_EN
    output logic [3:0]          score_l,
    output logic [3:0]          score_r,
`endif
    output logic                state_dbg
);

    localparam int                CTR      = NUM_LEDS / 2;
    localparam logic [PW-1:0]     CTR_POS  = PW'(CTR);
    localparam logic [PW-1:0]     LAST_POS = PW'(NUM_LEDS - 1);
    localparam logic [NUM_LEDS-1:0] ONE    = {{(NUM_LEDS-1){1'b0}}, 1'b1};
    localparam logic [NUM_LEDS-1:0] CTR_LEDS = ONE << CTR;

    typedef enum logic {
        PLAY = 1'b0,
        WIN  = 1'b1
    } state_t;

    state_t        state;
    logic [PW-1:0] pos;
    logic          btn_l_q, btn_r_q, clr_q;
    // Set on the edge that enters WIN; leds_on follows one cycle later.
    logic          win_entry;

    logic          l_press, r_press, c_press;
    logic [PW-1:0] pos_nxt;

    assign l_press   = btn_l & ~btn_l_q;
    assign r_press   = btn_r & ~btn_r_q;
    assign c_press   = clr_btn & ~clr_q;
    assign state_dbg = state;

    // Simultaneous presses cancel. pos can never underflow/overflow here
    // because reaching either end moves the FSM to WIN, which freezes pos.
    always_comb begin
        pos_nxt = pos;
        if (l_press && !r_press) begin
            pos_nxt = pos - PW'(1);
        end else if (r_press && !l_press) begin
            pos_nxt = pos + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= PLAY;
            pos       <= CTR_POS;
            leds      <= CTR_LEDS;
            leds_on   <= 1'b0;
            clear     <= 1'b0;
            winner    <= 2'b00;
            win_entry <= 1'b0;
            btn_l_q   <= 1'b0;
            btn_r_q   <= 1'b0;
            clr_q     <= 1'b0;
`ifdef SCORE_EN
            score_l   <= 4'd0;
            score_r   <= 4'd0;
`endif
        end else begin
            // Edge flops track the buttons in every state, including WIN.
            btn_l_q   <= btn_l;
            btn_r_q   <= btn_r;
            clr_q     <= clr_btn;
            leds_on   <= 1'b0;
            clear     <= 1'b0;
            win_entry <= 1'b0;

            if (c_press) begin
                // Restart outranks any player press in the same cycle. A
                // pending leds_on is dropped so it never coincides with clear.
                state  <= PLAY;
                pos    <= CTR_POS;
                leds   <= CTR_LEDS;
                winner <= 2'b00;
                clear  <= 1'b1;
            end else begin
                case (state)
                    PLAY: begin
                        pos  <= pos_nxt;
                        leds <= ONE << pos_nxt;
                        if (pos_nxt == '0) begin
                            state     <= WIN;
                            winner    <= 2'b01;
                            win_entry <= 1'b1;
`ifdef SCORE_EN
                            if (score_l != 4'd15) score_l <= score_l + 4'd1;
`endif
                        end else if (pos_nxt == LAST_POS) begin
                            state     <= WIN;
                            winner    <= 2'b10;
                            win_entry <= 1'b1;
`ifdef SCORE_EN
                            if (score_r != 4'd15) score_r <= score_r + 4'd1;
`endif
                        end
                    end
                    WIN: begin
                        // Only the first cycle in WIN carries the pulse.
                        leds_on <= win_entry;
                    end
                    default: begin
                        state <= PLAY;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tug_game_ctrl.sv
// Testbench for tug_game_ctrl: table-driven directed vectors, hand-written
// multi-cycle sequences (held button, async reset, score saturation) and a
// randomized run, all checked against a rule-level reference model.
module tb_tug_game_ctrl;
  localparam int N   = 7;
  localparam int PW  = 3;
  localparam int CTR = N / 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic btn_l, btn_r, clr_btn;
  logic [N-1:0] leds;
  logic leds_on, clear;
  logic [1:0] winner;
  logic state_dbg;
`ifdef SCORE_EN
  logic [3:0] score_l, score_r;
`endif

  always #5 clk = ~clk;

  tug_game_ctrl #(.NUM_LEDS(N), .PW(PW)) dut (
    .clk(clk),
    .rst(rst),
    .btn_l(btn_l),
    .btn_r(btn_r),
    .clr_btn(clr_btn),
    .leds(leds),
    .leds_on(leds_on),
    .clear(clear),
    .winner(winner),
`ifdef SCORE_EN
    .score_l(score_l),
    .score_r(score_r),
`endif
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [N-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Game rules in plain integers: position, game-over flag, who won,
  // whether the win happened on the previous edge, and win tallies.
  int m_pos, m_win, m_sl, m_sr;
  bit m_over, m_just, m_pl, m_pr, m_pc;

  task automatic model_reset();
    m_pos = CTR; m_win = 0; m_over = 0; m_just = 0;
    m_sl = 0; m_sr = 0; m_pl = 0; m_pr = 0; m_pc = 0;
  endtask

  task automatic model_step(input bit l, input bit r, input bit c,
                            output bit e_on, output bit e_clr);
    bit lp, rp, cp;
    logic [N-1:0] e_leds;
    lp = l && !m_pl; rp = r && !m_pr; cp = c && !m_pc;
    m_pl = l; m_pr = r; m_pc = c;
    e_on = 0; e_clr = 0;
    if (cp) begin
      m_pos = CTR; m_win = 0; m_over = 0; m_just = 0; e_clr = 1;
    end else if (!m_over) begin
      m_pos = m_pos + int'(rp) - int'(lp);
      if (m_pos == 0) begin
        m_over = 1; m_win = 1; m_just = 1;
        if (m_sl < 15) m_sl++;
      end else if (m_pos == N - 1) begin
        m_over = 1; m_win = 2; m_just = 1;
        if (m_sr < 15) m_sr++;
      end
    end else begin
      e_on = m_just; m_just = 0;
    end
    e_leds = '0;
    e_leds[m_pos] = 1'b1;
    exp_q.push_back(e_leds);
  endtask

  // ---------------- driver ----------------
  // Drive inputs, let one rising edge sample them, check 1 ns later.
  task automatic tick(input bit l, input bit r, input bit c);
    bit e_on, e_clr;
    btn_l = l; btn_r = r; clr_btn = c;
    @(posedge clk);
    #1;
    model_step(l, r, c, e_on, e_clr);
    chk("leds", 32'(leds), 32'(exp_q.pop_front()));
    chk("leds_on", 32'(leds_on), 32'(e_on));
    chk("clear", 32'(clear), 32'(e_clr));
    chk("winner", 32'(winner), 32'(m_win));
    chk("state", 32'(state_dbg), 32'(m_over));
`ifdef SCORE_EN
    chk("score_l", 32'(score_l), 32'(m_sl));
    chk("score_r", 32'(score_r), 32'(m_sr));
`endif
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit l, r, c;
    logic [N-1:0] leds;
    bit on, clr;
    logic [1:0] win;
  } vec_t;
  vec_t tbl[$];

  initial begin
    rst = 1'b1; btn_l = 0; btn_r = 0; clr_btn = 0;
    model_reset();

    // three left pulses to a left win, then ignored press, restart,
    // simultaneous rise, restart colliding with a right press
    tbl.push_back('{1,0,0, 7'b0000100, 0,0, 2'b00});
    tbl.push_back('{0,0,0, 7'b0000100, 0,0, 2'b00});
    tbl.push_back('{1,0,0, 7'b0000010, 0,0, 2'b00});
    tbl.push_back('{0,0,0, 7'b0000010, 0,0, 2'b00});
    tbl.push_back('{1,0,0, 7'b0000001, 0,0, 2'b01});
    tbl.push_back('{0,0,0, 7'b0000001, 1,0, 2'b01});
    tbl.push_back('{0,0,0, 7'b0000001, 0,0, 2'b01});
    tbl.push_back('{0,1,0, 7'b0000001, 0,0, 2'b01});
    tbl.push_back('{0,0,0, 7'b0000001, 0,0, 2'b01});
    tbl.push_back('{0,0,1, 7'b0001000, 0,1, 2'b00});
    tbl.push_back('{0,0,0, 7'b0001000, 0,0, 2'b00});
    tbl.push_back('{1,1,0, 7'b0001000, 0,0, 2'b00});
    tbl.push_back('{0,0,0, 7'b0001000, 0,0, 2'b00});
    tbl.push_back('{0,1,1, 7'b0001000, 0,1, 2'b00});
    tbl.push_back('{0,0,0, 7'b0001000, 0,0, 2'b00});
    tbl.push_back('{1,0,0, 7'b0000100, 0,0, 2'b00});
    tbl.push_back('{0,0,0, 7'b0000100, 0,0, 2'b00});

    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("reset_leds", 32'(leds), 32'(7'b0001000));
    chk("reset_winner", 32'(winner), 32'd0);
    chk("reset_leds_on", 32'(leds_on), 32'd0);
    chk("reset_clear", 32'(clear), 32'd0);
    chk("reset_state", 32'(state_dbg), 32'd0);

    foreach (tbl[i]) begin
      tick(tbl[i].l, tbl[i].r, tbl[i].c);
      chk($sformatf("tbl%0d_leds", i), 32'(leds), 32'(tbl[i].leds));
      chk($sformatf("tbl%0d_leds_on", i), 32'(leds_on), 32'(tbl[i].on));
      chk($sformatf("tbl%0d_clear", i), 32'(clear), 32'(tbl[i].clr));
      chk($sformatf("tbl%0d_winner", i), 32'(winner), 32'(tbl[i].win));
    end

    // back to centre, then btn_r held 20 cycles moves exactly one step
    tick(0, 0, 1); tick(0, 0, 0);
    for (int i = 0; i < 20; i++) tick(0, 1, 0);
    tick(0, 0, 0);
    chk("held_r_one_step", 32'(leds), 32'(7'b0010000));

    // right win: pos 4 -> 5 -> 6
    tick(0, 1, 0); tick(0, 0, 0);
    tick(0, 1, 0);
    chk("right_win_leds", 32'(leds), 32'(7'b1000000));
    chk("right_win_winner", 32'(winner), 32'd2);
    chk("right_win_no_early_pulse", 32'(leds_on), 32'd0);
    tick(0, 0, 0);
    chk("right_win_pulse", 32'(leds_on), 32'd1);
    tick(0, 0, 0);
    chk("right_win_pulse_once", 32'(leds_on), 32'd0);

    // restart, honour a press right after restart, then async reset at pos 5
    tick(0, 0, 1);
    tick(0, 1, 0);
    chk("press_after_restart", 32'(leds), 32'(7'b0010000));
    tick(0, 0, 0); tick(0, 1, 0); tick(0, 0, 0);
    chk("pos5", 32'(leds), 32'(7'b0100000));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_leds", 32'(leds), 32'(7'b0001000));
    chk("async_rst_clear", 32'(clear), 32'd0);
    chk("async_rst_winner", 32'(winner), 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    model_reset();
    tick(0, 0, 0);
    chk("post_rst_no_clear", 32'(clear), 32'd0);

    // 17 right wins separated by restarts
    for (int w = 0; w < 17; w++) begin
      for (int k = 0; k < 3; k++) begin
        tick(0, 1, 0); tick(0, 0, 0);
      end
      tick(0, 0, 1); tick(0, 0, 0);
    end
`ifdef SCORE_EN
    chk("score_r_saturated", 32'(score_r), 32'd15);
    chk("score_l_zero", 32'(score_l), 32'd0);
`endif

    // randomized play against the model
    for (int i = 0; i < 3000; i++) begin
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected end before 2000000");
    $fatal(1, "timeout");
  end
endmodule
